// File: rtl/gate_pkg.sv
// Shared constants and types for the basic gate array and its bench.
package gate_pkg;

    localparam int unsigned GATE_MAX_WIDTH = 64;

    typedef enum logic [1:0] {
        GATE_AND,
        GATE_NAND,
        GATE_NOR
    } gate_op_e;

endpackage

// File: rtl/basic_gate_array_if.sv
// Operand, result and valid signals of the basic gate array.
interface basic_gate_array_if #(
    parameter int unsigned WIDTH = 1
);
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             in_valid;
    logic [WIDTH-1:0] y_and;
    logic [WIDTH-1:0] y_nand;
    logic [WIDTH-1:0] y_nor;
    logic [WIDTH-1:0] q_and;
    logic [WIDTH-1:0] q_nand;
    logic [WIDTH-1:0] q_nor;
    logic             out_valid;

    modport master (
        output a, b, in_valid,
        input  y_and, y_nand, y_nor, q_and, q_nand, q_nor, out_valid
    );

    modport slave (
        input  a, b, in_valid,
        output y_and, y_nand, y_nor, q_and, q_nand, q_nor, out_valid
    );
endinterface

// File: rtl/gate_slice.sv
// Single-bit combinational AND/NAND/NOR cell.
module gate_slice (
    input  logic a,
    input  logic b,
    output logic y_and,
    output logic y_nand,
    output logic y_nor
);
    always_comb begin
        y_and  = a & b;
        y_nand = ~(a & b);
        y_nor  = ~(a | b);
    end
endmodule

// File: rtl/basic_gate_array.sv
// Bitwise AND/NAND/NOR array with combinational outputs and a 1-cycle registered copy.
module basic_gate_array
    import gate_pkg::*;
#(
    parameter int unsigned WIDTH = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    basic_gate_array_if.slave  bus
);
    if (WIDTH < 1 || WIDTH > GATE_MAX_WIDTH) begin : g_width_check
        $error("basic_gate_array: WIDTH out of range");
    end

    logic [WIDTH-1:0] y_and;
    logic [WIDTH-1:0] y_nand;
    logic [WIDTH-1:0] y_nor;

    for (genvar i = 0; i < WIDTH; i++) begin : g_slice
        gate_slice u_slice (
            .a      (bus.a[i]),
            .b      (bus.b[i]),
            .y_and  (y_and[i]),
            .y_nand (y_nand[i]),
            .y_nor  (y_nor[i])
        );
    end

    logic [WIDTH-1:0] q_and_d, q_and_q;
    logic [WIDTH-1:0] q_nand_d, q_nand_q;
    logic [WIDTH-1:0] q_nor_d, q_nor_q;
    logic             valid_d, valid_q;

    // Capture only on in_valid; otherwise hold, so q_* must be qualified by out_valid.
    always_comb begin
        q_and_d  = q_and_q;
        q_nand_d = q_nand_q;
        q_nor_d  = q_nor_q;
        valid_d  = bus.in_valid;
        if (bus.in_valid) begin
            q_and_d  = y_and;
            q_nand_d = y_nand;
            q_nor_d  = y_nor;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_and_q  <= '0;
            q_nand_q <= '0;
            q_nor_q  <= '0;
            valid_q  <= 1'b0;
        end else begin
            q_and_q  <= q_and_d;
            q_nand_q <= q_nand_d;
            q_nor_q  <= q_nor_d;
            valid_q  <= valid_d;
        end
    end

    assign bus.y_and     = y_and;
    assign bus.y_nand    = y_nand;
    assign bus.y_nor     = y_nor;
    assign bus.q_and     = q_and_q;
    assign bus.q_nand    = q_nand_q;
    assign bus.q_nor     = q_nor_q;
    assign bus.out_valid = valid_q;
endmodule

// File: tb/tb_basic_gate_array.sv
// Directed and random checks of basic_gate_array at WIDTH=1 and WIDTH=8.
module tb_basic_gate_array;
    import gate_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    basic_gate_array_if #(.WIDTH(1)) bus1 ();
    basic_gate_array_if #(.WIDTH(8)) bus8 ();

    basic_gate_array #(.WIDTH(1)) u_dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus1)
    );

    basic_gate_array #(.WIDTH(8)) u_dut8 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus8)
    );

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] gate_ref(input gate_op_e op, input logic [7:0] a,
                                            input logic [7:0] b);
        logic [7:0] r;
        unique case (op)
            GATE_AND:  r = a & b;
            GATE_NAND: r = ~(a & b);
            GATE_NOR:  r = ~(a | b);
            default:   r = 'x;
        endcase
        return r;
    endfunction

    task automatic check_y8(input string tag, input logic [7:0] ea, input logic [7:0] en,
                            input logic [7:0] eo);
        check({tag, ".y_and"},  64'(bus8.y_and),  64'(ea));
        check({tag, ".y_nand"}, 64'(bus8.y_nand), 64'(en));
        check({tag, ".y_nor"},  64'(bus8.y_nor),  64'(eo));
    endtask

    task automatic check_q8(input string tag, input logic [7:0] ea, input logic [7:0] en,
                            input logic [7:0] eo, input logic ev);
        check({tag, ".q_and"},     64'(bus8.q_and),     64'(ea));
        check({tag, ".q_nand"},    64'(bus8.q_nand),    64'(en));
        check({tag, ".q_nor"},     64'(bus8.q_nor),     64'(eo));
        check({tag, ".out_valid"}, 64'(bus8.out_valid), 64'(ev));
    endtask

    initial begin
        logic [0:3] tt_and;
        logic [0:3] tt_nand;
        logic [0:3] tt_nor;
        logic [7:0] ea, en, eo, ra, rb, inv;
        logic       ev, riv;
        logic [1:0] ab;

        tt_and  = 4'b0001;
        tt_nand = 4'b1110;
        tt_nor  = 4'b1000;

        bus1.a = 1'b0; bus1.b = 1'b0; bus1.in_valid = 1'b0;
        bus8.a = 8'h00; bus8.b = 8'h00; bus8.in_valid = 1'b0;

        // Reset state; combinational outputs remain live during reset.
        #2;
        check("rst.q1_and",  64'(bus1.q_and),     64'(0));
        check("rst.q1_nand", 64'(bus1.q_nand),    64'(0));
        check("rst.q1_nor",  64'(bus1.q_nor),     64'(0));
        check("rst.ov1",     64'(bus1.out_valid), 64'(0));
        check_q8("rst.w8", 8'h00, 8'h00, 8'h00, 1'b0);
        bus8.a = 8'hF0; bus8.b = 8'hCC; bus8.in_valid = 1'b1;
        #1;
        check_y8("rst.y8", 8'hC0, 8'h3F, 8'h03);
        @(posedge clk); #1;
        check_q8("rst.nocap", 8'h00, 8'h00, 8'h00, 1'b0);
        bus8.in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        // WIDTH=1 truth table, combinational and registered.
        for (int i = 0; i < 4; i++) begin
            ab = 2'(i);
            bus1.a = ab[1];
            bus1.b = ab[0];
            bus1.in_valid = 1'b1;
            #1;
            check($sformatf("tt%0d.y_and", i),  64'(bus1.y_and),  64'(tt_and[i]));
            check($sformatf("tt%0d.y_nand", i), 64'(bus1.y_nand), 64'(tt_nand[i]));
            check($sformatf("tt%0d.y_nor", i),  64'(bus1.y_nor),  64'(tt_nor[i]));
            @(posedge clk); #1;
            check($sformatf("tt%0d.q_and", i),  64'(bus1.q_and),     64'(tt_and[i]));
            check($sformatf("tt%0d.q_nand", i), 64'(bus1.q_nand),    64'(tt_nand[i]));
            check($sformatf("tt%0d.q_nor", i),  64'(bus1.q_nor),     64'(tt_nor[i]));
            check($sformatf("tt%0d.ov", i),     64'(bus1.out_valid), 64'(1));
        end
        bus1.in_valid = 1'b0;
        bus1.a = 1'b0;
        @(posedge clk); #1;
        check("tt.hold.q_and",  64'(bus1.q_and),     64'(1));
        check("tt.hold.q_nand", 64'(bus1.q_nand),    64'(0));
        check("tt.hold.ov",     64'(bus1.out_valid), 64'(0));

        // WIDTH=8 directed vector.
        bus8.a = 8'hF0; bus8.b = 8'hCC; bus8.in_valid = 1'b1;
        #1;
        check_y8("w8", 8'hC0, 8'h3F, 8'h03);
        @(posedge clk); #1;
        check_q8("w8", 8'hC0, 8'h3F, 8'h03, 1'b1);

        // Single pulse, then hold while operands move.
        bus8.a = 8'h5A; bus8.b = 8'h0F; bus8.in_valid = 1'b1;
        @(posedge clk); #1;
        check_q8("pulse", 8'h0A, 8'hF5, 8'hA0, 1'b1);
        bus8.in_valid = 1'b0; bus8.a = 8'hFF; bus8.b = 8'hFF;
        @(posedge clk); #1;
        check_q8("hold1", 8'h0A, 8'hF5, 8'hA0, 1'b0);
        bus8.a = 8'h00; bus8.b = 8'h33;
        #1;
        check_y8("hold2", 8'h00, 8'hFF, 8'hCC);
        @(posedge clk); #1;
        check_q8("hold2", 8'h0A, 8'hF5, 8'hA0, 1'b0);

        // Reset asserted between edges while out_valid is high.
        bus8.a = 8'h3C; bus8.b = 8'hA5; bus8.in_valid = 1'b1;
        @(posedge clk); #1;
        check_q8("mid.pre", 8'h24, 8'hDB, 8'h42, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check_q8("mid.rst", 8'h00, 8'h00, 8'h00, 1'b0);
        check_y8("mid.rst", 8'h24, 8'hDB, 8'h42);
        bus8.a = 8'h0F; bus8.b = 8'hF0;
        #1;
        check_y8("mid.rst2", 8'h00, 8'hFF, 8'h00);
        bus8.in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        // Random traffic against the reference model.
        ea = 8'h00; en = 8'h00; eo = 8'h00; ev = 1'b0;
        for (int n = 0; n < 1000; n++) begin
            ra  = 8'($urandom);
            rb  = 8'($urandom);
            riv = 1'($urandom_range(0, 1));
            bus8.a = ra; bus8.b = rb; bus8.in_valid = riv;
            #1;
            check_y8($sformatf("rnd%0d", n), gate_ref(GATE_AND, ra, rb),
                     gate_ref(GATE_NAND, ra, rb), gate_ref(GATE_NOR, ra, rb));
            if (riv) begin
                ea = gate_ref(GATE_AND, ra, rb);
                en = gate_ref(GATE_NAND, ra, rb);
                eo = gate_ref(GATE_NOR, ra, rb);
            end
            ev = riv;
            @(posedge clk); #1;
            check_q8($sformatf("rnd%0d", n), ea, en, eo, ev);
            if (bus8.out_valid) begin
                inv = ~bus8.q_and;
                check($sformatf("rnd%0d.inv_nand", n), 64'(bus8.q_nand), 64'(inv));
                check($sformatf("rnd%0d.inv_nor", n), 64'(bus8.q_nor & bus8.q_and), 64'(0));
            end
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule

// File: doc/basic_gate_array.md
Name: basic_gate_array

Overview:
- Bitwise two-input logic block producing AND, NAND and NOR of operands a and b.
- Each function is provided both combinationally (zero latency) and as a registered copy with a valid flag (1-cycle latency).
- Used as a leaf datapath primitive and as the reference cell for gate-level truth-table checks. WIDTH=1 gives the classic single-bit gates.

Parameters:
- WIDTH, 1, operand and result width in bits (legal range 1..64).

Ports:
- clk  input  1  single system clock; all registers update on its rising edge.
- rst_n  input  1  reset, asynchronous assert, active-low.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- in_valid  input  1  qualifies a/b for capture into the registered outputs.
- y_and  output  WIDTH  combinational a & b.
- y_nand  output  WIDTH  combinational ~(a & b).
- y_nor  output  WIDTH  combinational ~(a | b).
- q_and  output  WIDTH  registered a & b.
- q_nand  output  WIDTH  registered ~(a & b).
- q_nor  output  WIDTH  registered ~(a | b).
- out_valid  output  1  high for one cycle when q_* hold a freshly captured result.

Behaviour:
- Combinational path:
  - y_and, y_nand and y_nor are pure functions of a and b, bit for bit. Bit i depends only on a[i] and b[i].
  - No dependence on clk, rst_n or in_valid; outputs are valid during reset.
  - Per-bit truth table (a,b -> and,nand,nor): 00 -> 0,1,1; 01 -> 0,1,0; 10 -> 0,1,0; 11 -> 1,0,0.
- Registered path:
  - On a rising clk with in_valid=1, q_and/q_nand/q_nor capture the current combinational values and out_valid goes to 1 the next cycle. Latency is exactly 1 cycle.
  - On a rising clk with in_valid=0, q_* hold their previous value and out_valid goes to 0.
  - Back-to-back in_valid gives a new result every cycle. No backpressure; no ready signal.
- Reset:
  - rst_n=0 immediately, independent of clk, forces q_and=0, q_nand=0, q_nor=0, out_valid=0.
  - Registered outputs reset to all-zeros, not to gate-consistent values; consumers must qualify q_* with out_valid.
  - Release of rst_n is synchronised by the parent. The first capture is possible on the first rising edge after release.
  - Reset asserted mid-stream discards any pending result; out_valid drops in the same instant.
- Invariant when out_valid=1: q_nand == ~q_and, and (q_nor & q_and) == 0.
- X handling: no special handling; X on a bit propagates only to that bit's outputs.

Decomposition:
- Shared package gate_pkg:
  - constant GATE_MAX_WIDTH = 64.
  - typedef gate_op_e {GATE_AND, GATE_NAND, GATE_NOR} for bench reporting and future muxing.
- One natural sub-module: gate_slice, the single-bit combinational AND/NAND/NOR cell.
  - Instantiated WIDTH times via generate.
  - The top adds the capture register and valid pipeline.

Test Plan:
- WIDTH=1, apply ab=00, 01, 10, 11 at 10 ns intervals -> y_and=0,0,0,1; y_nand=1,1,1,0; y_nor=1,0,0,0.
- Same sequence with in_valid=1 each cycle -> q_* show identical values one clk later; out_valid=1 each following cycle.
- WIDTH=8, a=8'hF0, b=8'hCC, in_valid=1 -> y_and=8'hC0, y_nand=8'h3F, y_nor=8'h03; q_* match next edge.
- in_valid pulsed once then held 0 with a/b changing -> q_* hold the captured value; out_valid high for exactly one cycle.
- Assert rst_n=0 between clock edges while out_valid=1 -> q_*=0 and out_valid=0 immediately; y_* still track a/b.
- Random a/b/in_valid over 1000 cycles -> y_* and q_* match the software model; the out_valid invariants always hold.
